// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction register in front of a synchronous instruction ROM
// Optional HALT detection is compiled in with `define FETCH_HALT_EN.
module fetch_unit #(
  parameter int          ADDR_W  = 7,
  parameter int          DATA_W  = 16,
  parameter int          ROM_LAT = 1,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic              ir_ack,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  // Counter reload value: the capture happens ROM_LAT edges after the fetch edge.
  localparam logic [1:0] LP_LAT_M1 = 2'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] LP_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_cnt;
  logic [1:0]          w_next_cnt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_next_pc;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   w_next_ir;
  logic                r_ir_valid;
  logic                w_next_ir_valid;
  logic                w_op_is_halt;
  logic                w_halt_blk;
  logic                w_halt_set;

  assign w_op_is_halt = (mem_q[DATA_W-1 -: 4] == HALT_OP);

`ifdef FETCH_HALT_EN
  logic r_halted;

  // Sticky HALT flag; only reset clears it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_halted <= 1'b0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halt_blk = r_halted;
  assign halted     = r_halted;
`else
  logic w_unused_halt;
  assign w_unused_halt = w_op_is_halt ^ w_halt_set;
  assign w_halt_blk    = 1'b0;
  assign halted        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath next values; everything held unless a branch below changes it.
  always_comb begin
    w_next_state    = r_state;
    w_next_cnt      = r_cnt;
    w_next_pc       = r_pc;
    w_next_ir       = r_ir;
    w_next_ir_valid = r_ir_valid;
    w_halt_set      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pc_load) begin
          w_next_pc = pc_in;
        end else if (fetch_req && !w_halt_blk) begin
          w_next_state = S_WAIT;
          w_next_cnt   = LP_LAT_M1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_next_ir       = mem_q;
          w_next_ir_valid = 1'b1;
          w_next_pc       = r_pc + LP_PC_ONE;
          w_next_state    = S_VALID;
          w_halt_set      = w_op_is_halt;
        end else begin
          w_next_cnt = r_cnt - 2'd1;
        end
      end
      S_VALID: begin
        if (ir_ack) begin
          w_next_ir_valid = 1'b0;
          if (pc_load) begin
            w_next_pc    = pc_in;
            w_next_state = S_IDLE;
          end else if (fetch_req && !w_halt_blk) begin
            w_next_state = S_WAIT;
            w_next_cnt   = LP_LAT_M1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath registers; reset aborts any in-flight read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt      <= 2'd0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_cnt      <= w_next_cnt;
      r_pc       <= w_next_pc;
      r_ir       <= w_next_ir;
      r_ir_valid <= w_next_ir_valid;
    end
  end

  assign mem_addr = r_pc;
  assign pc       = r_pc;
  assign ir       = r_ir;
  assign ir_valid = r_ir_valid;
  assign busy     = (r_state == S_WAIT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit with a 1-cycle registered ROM
module tb_fetch_unit;

  logic        clock;
  logic        reset_n;
  logic        fetch_req;
  logic        ir_ack;
  logic        pc_load;
  logic [6:0]  pc_in;
  logic [6:0]  mem_addr;
  logic [15:0] mem_q;
  logic [15:0] ir;
  logic        ir_valid;
  logic [6:0]  pc;
  logic        busy;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] sb[$];

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  fetch_unit #(.ADDR_W(7), .DATA_W(16), .ROM_LAT(1), .HALT_OP(4'hF)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_req(fetch_req), .ir_ack(ir_ack),
    .pc_load(pc_load), .pc_in(pc_in), .mem_addr(mem_addr), .mem_q(mem_q),
    .ir(ir), .ir_valid(ir_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rom_word(input logic [6:0] a);
    if (a == 7'd5) return 16'hF005;
    return 16'hA000 | {9'b0, a};
  endfunction

  // ROM model: registered address, one clock of read latency
  always @(posedge clock) mem_q <= rom_word(mem_addr);

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ir(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) e = 16'hxxxx;
    else e = sb.pop_front();
    chk(tag, {16'd0, ir}, {16'd0, e});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    fetch_req = 1'b0; ir_ack = 1'b0; pc_load = 1'b0; pc_in = 7'd0;
    step(); step();
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", mem_addr, 0);

    // single fetch
    fetch_req = 1'b1; sb.push_back(rom_word(7'd0));
    step();
    fetch_req = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_valid_early", ir_valid, 0);
    chk("t1_pc_held", pc, 0);
    step();
    chk("t1_busy_off", busy, 0);
    chk("t1_valid", ir_valid, 1);
    chk_ir("t1_ir");
    chk("t1_pc", pc, 1);
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    chk("t1_ack_clr", ir_valid, 0);
    chk("t1_ir_retained", ir, 16'hA000);

    // back-to-back fetches from a fresh reset
    do_reset();
    fetch_req = 1'b1; sb.push_back(rom_word(7'd0));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_busy", busy, 1);
      chk("t2_valid_off", ir_valid, 0);
      step();
      chk("t2_valid", ir_valid, 1);
      chk_ir("t2_ir");
      chk("t2_pc", pc, i + 1);
      if (i < 3) sb.push_back(rom_word(7'(i + 1)));
      else fetch_req = 1'b0;
      ir_ack = 1'b1;
    end
    step();
    ir_ack = 1'b0;
    chk("t2_end_valid", ir_valid, 0);
    chk("t2_end_busy", busy, 0);
    chk("t2_end_pc", pc, 4);

    // jump with a simultaneous fetch_req: load wins, no fetch starts
    fetch_req = 1'b1; sb.push_back(rom_word(7'd4));
    step();
    fetch_req = 1'b0;
    step();
    chk_ir("t3_ir4");
    ir_ack = 1'b1; pc_load = 1'b1; pc_in = 7'd127; fetch_req = 1'b1;
    step();
    ir_ack = 1'b0; pc_load = 1'b0; fetch_req = 1'b0;
    chk("t3_valid", ir_valid, 0);
    chk("t3_busy", busy, 0);
    chk("t3_pc", pc, 127);
    chk("t3_addr", mem_addr, 127);
    step();
    chk("t3_no_fetch", busy, 0);
    fetch_req = 1'b1; sb.push_back(rom_word(7'd127));
    step();
    fetch_req = 1'b0;
    step();
    chk("t3_valid2", ir_valid, 1);
    chk_ir("t3_ir127");
    chk("t3_wrap", pc, 0);
    ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;

    // pc_load ignored in WAIT, inputs ignored while VALID without ack
    fetch_req = 1'b1; sb.push_back(rom_word(7'd0));
    step();
    fetch_req = 1'b0; pc_load = 1'b1; pc_in = 7'd20;
    step();
    chk("t4_valid", ir_valid, 1);
    chk("t4_pc", pc, 1);
    chk_ir("t4_ir");
    fetch_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", ir_valid, 1);
      chk("t4_hold_ir", ir, 16'hA000);
      chk("t4_hold_pc", pc, 1);
      chk("t4_hold_busy", busy, 0);
    end
    fetch_req = 1'b0; pc_load = 1'b0; ir_ack = 1'b1;
    step();
    ir_ack = 1'b0;
    chk("t4_ack", ir_valid, 0);
    chk("t4_pc_after", pc, 1);

    // reset on the WAIT edge aborts the read
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    chk("t5_busy", busy, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t5_ir", ir, 0);
    chk("t5_valid", ir_valid, 0);
    chk("t5_pc", pc, 0);
    chk("t5_busy_off", busy, 0);
    step();
    chk("t5_no_late", ir_valid, 0);
    chk("t5_no_late_busy", busy, 0);

    // fetch addresses 0..5; address 5 holds the HALT opcode
    for (int a = 0; a < 6; a++) begin
      fetch_req = 1'b1; sb.push_back(rom_word(7'(a)));
      step();
      fetch_req = 1'b0;
      step();
      chk("t6_valid", ir_valid, 1);
      chk_ir("t6_ir");
      chk("t6_halted", halted, (a == 5) ? HALT_EN : 1'b0);
      ir_ack = 1'b1;
      step();
      ir_ack = 1'b0;
    end
    chk("t6_pc", pc, 6);
    fetch_req = 1'b1;
`ifdef FETCH_HALT_EN
    step();
    fetch_req = 1'b0;
    chk("t6_blocked_busy", busy, 0);
    step();
    chk("t6_blocked_valid", ir_valid, 0);
    chk("t6_blocked_ir", ir, 16'hF005);
    chk("t6_blocked_pc", pc, 6);
    chk("t6_still_halted", halted, 1);
`else
    sb.push_back(rom_word(7'd6));
    step();
    fetch_req = 1'b0;
    chk("t6_busy", busy, 1);
    step();
    chk("t6_valid6", ir_valid, 1);
    chk_ir("t6_ir6");
    chk("t6_pc7", pc, 7);
    chk("t6_not_halted", halted, 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
